// File: rtl/proc_scheduler.sv
// proc_scheduler: round-robin program scheduler with a saved-PC slot table.
// It stalls the core, saves the running PC, selects the next valid slot and
// issues a one-cycle PC load.
// Optional feature macro: SCHED_PREEMPT_EN. When it is defined, quantum expiry
// preempts the running program. When it is not defined, programs switch only
// on yield or end_prog.
module proc_scheduler #(
  parameter int NPROC = 4,
  parameter int PC_W  = 32,
  parameter int QW    = 16,
  parameter int QDEF  = 64,
  localparam int PID_W = $clog2(NPROC)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             step,
  input  logic             add_valid,
  input  logic [PC_W-1:0]  add_pc,
  output logic             add_ready,
  input  logic             def_quantum,
  input  logic [QW-1:0]    quantum_val,
  input  logic             yield,
  input  logic             end_prog,
  input  logic [PC_W-1:0]  cur_pc,
  output logic             switch_req,
  output logic             load_pc,
  output logic [PC_W-1:0]  load_addr,
  output logic [PID_W-1:0] cur_pid,
  output logic             running,
  output logic [NPROC-1:0] active_mask
);

  typedef enum logic [1:0] {IDLE, RUN, SELECT, LOAD} state_t;

  state_t           state_q, state_d;
  logic [NPROC-1:0] valid_q, valid_d;
  logic [PC_W-1:0]  table_q [NPROC];
  logic [PC_W-1:0]  table_d [NPROC];
  logic [PID_W-1:0] cur_pid_q, cur_pid_d;
  logic [PID_W-1:0] next_pid_q, next_pid_d;
  logic [PC_W-1:0]  load_addr_q, load_addr_d;
  logic [PID_W-1:0] free_idx;
  logic [PID_W-1:0] found_idx;
  logic             found;
  logic             expire;
  logic             add_fire;
  logic             switch_event;

`ifdef SCHED_PREEMPT_EN
  logic [QW-1:0]    qcnt_q, qcnt_d;
  logic [QW-1:0]    quantum_q, quantum_d;
  assign expire = (qcnt_q == quantum_q - QW'(1));
`else
  // Quantum inputs have no function in the cooperative build.
  logic unused_quantum;
  assign unused_quantum = ^{def_quantum, quantum_val};
  assign expire = 1'b0;
`endif

  assign add_ready    = ~&valid_q;
  assign add_fire     = add_valid && add_ready;
  assign switch_event = step && (end_prog || yield || expire);

  // Find the lowest free slot. A slot freed this cycle is still seen as busy.
  always_comb begin
    free_idx = '0;
    for (int i = NPROC - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = PID_W'(i);
    end
  end

  // Round-robin search starting at cur_pid+1. cur_pid itself is checked last.
  always_comb begin
    logic [PID_W-1:0] idx;
    idx       = '0;
    found     = 1'b0;
    found_idx = '0;
    for (int i = NPROC; i >= 1; i--) begin
      idx = cur_pid_q + PID_W'(i);
      if (valid_q[idx]) begin
        found     = 1'b1;
        found_idx = idx;
      end
    end
  end

  // Next-state logic and slot table bookkeeping.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    table_d     = table_q;
    cur_pid_d   = cur_pid_q;
    next_pid_d  = next_pid_q;
    load_addr_d = load_addr_q;
`ifdef SCHED_PREEMPT_EN
    qcnt_d      = qcnt_q;
    quantum_d   = quantum_q;
    if (def_quantum && (quantum_val != '0)) quantum_d = quantum_val;
`endif

    if (add_fire) begin
      valid_d[free_idx] = 1'b1;
      table_d[free_idx] = add_pc;
    end

    case (state_q)
      IDLE: begin
        if (|valid_d) state_d = SELECT;
      end
      RUN: begin
`ifdef SCHED_PREEMPT_EN
        if (step) qcnt_d = qcnt_q + QW'(1);
`endif
        if (switch_event) begin
          if (end_prog) valid_d[cur_pid_q] = 1'b0;
          else          table_d[cur_pid_q] = cur_pc;
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (found) begin
          next_pid_d  = found_idx;
          load_addr_d = table_q[found_idx];
          state_d     = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        cur_pid_d = next_pid_q;
`ifdef SCHED_PREEMPT_EN
        qcnt_d    = '0;
`endif
        state_d   = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers. Reset aborts any switch in progress immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      cur_pid_q   <= '0;
      next_pid_q  <= '0;
      load_addr_q <= '0;
      for (int i = 0; i < NPROC; i++) table_q[i] <= '0;
`ifdef SCHED_PREEMPT_EN
      qcnt_q      <= '0;
      quantum_q   <= QW'(QDEF);
`endif
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      cur_pid_q   <= cur_pid_d;
      next_pid_q  <= next_pid_d;
      load_addr_q <= load_addr_d;
      table_q     <= table_d;
`ifdef SCHED_PREEMPT_EN
      qcnt_q      <= qcnt_d;
      quantum_q   <= quantum_d;
`endif
    end
  end

  assign switch_req  = (state_q == SELECT) || (state_q == LOAD);
  assign load_pc     = (state_q == LOAD);
  assign load_addr   = load_addr_q;
  assign cur_pid     = cur_pid_q;
  assign running     = (state_q == RUN);
  assign active_mask = valid_q;

endmodule

// File: tb/tb_proc_scheduler.sv
// Testbench for proc_scheduler: random and directed stimulus, a program-level
// reference model and a scoreboard of expected PC loads.
module tb_proc_scheduler;

  logic        clock;
  logic        reset_n;
  logic        step;
  logic        add_valid;
  logic [31:0] add_pc;
  logic        add_ready;
  logic        def_quantum;
  logic [15:0] quantum_val;
  logic        yield;
  logic        end_prog;
  logic [31:0] cur_pc;
  logic        switch_req;
  logic        load_pc;
  logic [31:0] load_addr;
  logic [1:0]  cur_pid;
  logic        running;
  logic [3:0]  active_mask;

  proc_scheduler dut (
    .clock(clock), .reset_n(reset_n), .step(step),
    .add_valid(add_valid), .add_pc(add_pc), .add_ready(add_ready),
    .def_quantum(def_quantum), .quantum_val(quantum_val),
    .yield(yield), .end_prog(end_prog), .cur_pc(cur_pc),
    .switch_req(switch_req), .load_pc(load_pc), .load_addr(load_addr),
    .cur_pid(cur_pid), .running(running), .active_mask(active_mask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          stamp;
    logic [31:0] addr;
    int          pid;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: which programs exist, their saved PCs, who runs, and
  // how many cycles of a context switch remain.
  bit [3:0]    m_valid   = '0;
  logic [31:0] m_tab [4];
  int          m_pid     = 0;
  bit          m_running = 1'b0;
  int          m_sw      = 0;
  int          m_tgt     = -1;
  logic [15:0] m_quant   = 16'd64;
  logic [15:0] m_cnt     = '0;
  int          ecnt      = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, got, exp, ecnt);
    end
  endtask

  function automatic int pick(bit [3:0] v, int from);
    int r;
    r = -1;
    for (int i = 1; i <= 4; i++) begin
      if (r < 0 && v[(from + i) % 4]) r = (from + i) % 4;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_valid   = '0;
    m_pid     = 0;
    m_running = 1'b0;
    m_sw      = 0;
    m_tgt     = -1;
    m_quant   = 16'd64;
    m_cnt     = '0;
    exp_q.delete();
  endtask

  // A switch begins: choose the next program from those present now.
  task automatic start_switch(bit [3:0] v);
    exp_t e;
    m_tgt = pick(v, m_pid);
    if (m_tgt >= 0) begin
      m_sw    = 2;
      e.stamp = ecnt + 1;
      e.addr  = m_tab[m_tgt];
      e.pid   = m_tgt;
      exp_q.push_back(e);
    end else begin
      m_sw = 1;
    end
  endtask

  task automatic model_step();
    bit [3:0] nv;
    bit       acc;
    bit       expiry;
    int       slot;
    nv   = m_valid;
    acc  = add_valid && (m_valid != 4'hF);
    slot = -1;
    for (int i = 3; i >= 0; i--) if (!m_valid[i]) slot = i;
    if (acc) begin
      nv[slot]    = 1'b1;
      m_tab[slot] = add_pc;
    end
`ifdef SCHED_PREEMPT_EN
    expiry = (m_cnt == m_quant - 16'd1);
`else
    expiry = 1'b0;
`endif
    if (m_running) begin
      if (step) m_cnt = m_cnt + 16'd1;
      if (step && (end_prog || yield || expiry)) begin
        if (end_prog) nv[m_pid] = 1'b0;
        else          m_tab[m_pid] = cur_pc;
        m_running = 1'b0;
        start_switch(nv);
      end
    end else if (m_sw > 0) begin
      m_sw--;
      if (m_sw == 0 && m_tgt >= 0) begin
        m_running = 1'b1;
        m_pid     = m_tgt;
        m_cnt     = '0;
      end
    end else if (nv != 4'h0) begin
      start_switch(nv);
    end
    m_valid = nv;
`ifdef SCHED_PREEMPT_EN
    if (def_quantum && quantum_val != 16'd0) m_quant = quantum_val;
`endif
  endtask

  // Model advances on every active clock edge, or resets with the DUT.
  initial begin
    model_reset();
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) model_reset();
      else begin
        ecnt++;
        model_step();
      end
    end
  end

  // Monitor: compare visible state each cycle and pop the expected PC loads.
  initial begin
    bit exp_ld;
    forever begin
      @(negedge clock);
      chk("running", running, m_running);
      chk("switch_req", switch_req, m_sw > 0);
      chk("active_mask", active_mask, m_valid);
      chk("add_ready", add_ready, m_valid != 4'hF);
      chk("cur_pid", cur_pid, m_pid);
      while (exp_q.size() > 0 && exp_q[0].stamp < ecnt) begin
        chk("load_missing", 0, 1);
        void'(exp_q.pop_front());
      end
      exp_ld = (exp_q.size() > 0) && (exp_q[0].stamp == ecnt);
      chk("load_pc", load_pc, exp_ld);
      if (exp_ld) begin
        if (load_pc) chk("load_addr", load_addr, exp_q[0].addr);
        $display("load pid=%0d addr=%08h (edge %0d)", exp_q[0].pid, load_addr, ecnt);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic set_in(bit av, logic [31:0] ap, bit st, bit y, bit e, bit dq, logic [15:0] qv);
    add_valid   = av;
    add_pc      = ap;
    step        = st;
    yield       = y;
    end_prog    = e;
    def_quantum = dq;
    quantum_val = qv;
    cur_pc      = $urandom;
  endtask

  task automatic cyc(bit av, logic [31:0] ap, bit st, bit y, bit e, bit dq, logic [15:0] qv);
    @(negedge clock);
    set_in(av, ap, st, y, e, dq, qv);
  endtask

  task automatic rand_cyc(int yield_pct);
    cyc($urandom_range(0, 99) < 10, $urandom, $urandom_range(0, 99) < 70,
        $urandom_range(0, 99) < yield_pct, $urandom_range(0, 99) < 4,
        $urandom_range(0, 99) < 3, 16'($urandom_range(0, 8)));
  endtask

  task automatic check_reset_outputs();
    chk("rst_switch_req", switch_req, 0);
    chk("rst_load_pc", load_pc, 0);
    chk("rst_load_addr", load_addr, 0);
    chk("rst_running", running, 0);
    chk("rst_add_ready", add_ready, 1);
    chk("rst_active_mask", active_mask, 0);
    chk("rst_cur_pid", cur_pid, 0);
  endtask

  initial begin
    bit hit;
    reset_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clock);
    check_reset_outputs();
    reset_n = 1'b1;

    // First program, then quantum 4 and continuous stepping.
    cyc(1, 32'h10, 0, 0, 0, 1, 16'd4);
    repeat (5) cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(1, 32'h40, 1, 0, 0, 0, 0);
    repeat (12) cyc(0, 0, 1, 0, 0, 0, 0);
    // Fill every slot, then one add that must be dropped.
    cyc(1, 32'h80, 0, 0, 0, 0, 0);
    cyc(1, 32'hC0, 0, 0, 0, 0, 0);
    cyc(1, 32'h100, 0, 0, 0, 0, 0);
    // end_prog together with an add while full: add refused, then retried.
    cyc(1, 32'h200, 1, 0, 1, 0, 0);
    cyc(1, 32'h200, 0, 0, 0, 0, 0);
    repeat (4) cyc(0, 0, 1, 0, 0, 0, 0);
    // Yield-heavy traffic.
    repeat (40) cyc(0, 0, 1, 1, 0, 0, 0);

    repeat (3000) rand_cyc(5);

    // Reset pulse in the middle of a PC load.
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clock);
      if (m_sw == 2 && m_tgt >= 0) begin
        set_in(0, 0, 0, 0, 0, 0, 0);
        hit = 1'b1;
      end else begin
        set_in($urandom_range(0, 99) < 20, $urandom, 1, $urandom_range(0, 99) < 40, 0, 0, 0);
      end
    end
    if (hit) begin
      @(posedge clock);
      #1;
      reset_n = 1'b0;
      #1;
      check_reset_outputs();
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
    end else begin
      chk("reset_window", 0, 1);
    end

    repeat (1500) rand_cyc(8);
    repeat (10) cyc(0, 0, 0, 0, 0, 0, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
